// File: rtl/or_accum_pkg.sv
// Shared types and width helpers for the OR burst accumulator
// and neighbouring gate-result consumers.
package or_accum_pkg;

  typedef enum logic {ACCUM, HOLD} state_t;

  function automatic int ones_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int words_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/popcount_n.sv
// Parametric combinational popcount of an N-bit word.
// Result width is wide enough to hold N itself.
module popcount_n
  import or_accum_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         in_word,
  output logic [ones_w(N)-1:0] ones
);

  localparam int W = ones_w(N);

  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + W'(in_word[i]);
    end
  end

endmodule

// File: rtl/or_burst_accum.sv
// Sticky OR accumulator over a burst of F words, with
// valid/ready in and out and per-burst summary statistics.
module or_burst_accum
  import or_accum_pkg::*;
#(
  parameter int n   = 4,
  parameter int LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [n-1:0]             F_in,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [n-1:0]             out_mask,
  output logic [ones_w(n)-1:0]     out_ones,
  output logic [words_w(LEN)-1:0]  out_words,
  output logic                     out_all
);

  localparam int CW = words_w(LEN);

  state_t          state_q, state_d;
  logic [n-1:0]    mask_q, mask_d;
  logic [CW-1:0]   count_q, count_d;
  logic            hold;

  assign hold = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    unique case (state_q)
      ACCUM: begin
        // clr wins over a word presented in the same cycle
        if (clr) begin
          mask_d  = '0;
          count_d = '0;
        end else if (in_valid) begin
          mask_d  = mask_q | F_in;
          count_d = count_q + CW'(1);
          if (count_q == CW'(LEN - 1) || in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (clr || out_ready) begin
          mask_d  = '0;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  // rst gates in_ready directly since the reset state is ACCUM
  assign in_ready  = ~rst & ~hold;
  assign out_valid = hold;
  assign out_mask  = hold ? mask_q : '0;
  assign out_words = hold ? count_q : '0;
  assign out_all   = hold & (&mask_q);

  popcount_n #(
    .N (n)
  ) u_popcount (
    .in_word (out_mask),
    .ones    (out_ones)
  );

endmodule

// File: doc/or_burst_accum.md
Name: or_burst_accum

Overview:
- Downstream consumer of the parametric n-bit OR gate's F output stream.
- Accumulates a burst of F words into a sticky OR mask using a valid/ready input handshake.
- Presents the burst result with summary statistics on a valid/ready output port.
- Used to collect "any bit ever set" flags across a window of gate results before the next pipeline stage.

Parameters:
- n, 4, width of each F word and of the accumulated mask
- LEN, 4, maximum number of words per burst (LEN >= 1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- clr  input  1  synchronous burst abort; discards the partial burst
- in_valid  input  1  F_in holds a valid word
- in_ready  output  1  block accepts a word this cycle
- F_in  input  n  word from the OR stage
- in_last  input  1  qualifies F_in as the final word of the burst (early termination)
- out_valid  output  1  burst result available
- out_ready  input  1  consumer takes the result
- out_mask  output  n  OR of all words accepted in the burst
- out_ones  output  $clog2(n+1)  popcount of out_mask
- out_words  output  $clog2(LEN+1)  number of words accepted in the burst
- out_all  output  1  out_mask is all ones

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
- While rst is asserted, all outputs are forced immediately:
  - state = ACCUM
  - mask = 0, count = 0
  - out_valid = 0, out_mask = 0, out_ones = 0, out_words = 0, out_all = 0
  - in_ready = 0
- State ACCUM:
  - in_ready = 1 when rst = 0.
  - A word is accepted when in_valid and in_ready are both 1 at the clk edge.
  - On accept: mask <= mask | F_in; count <= count + 1.
  - If count == LEN-1 or in_last == 1, the accept also moves the state to HOLD.
  - out_valid = 0 in ACCUM.
- State HOLD:
  - out_valid = 1, in_ready = 0.
  - out_mask, out_ones, out_words and out_all are registered/derived from mask and count, and stay stable until the handshake.
  - When out_valid and out_ready are both 1 at a clk edge: mask <= 0, count <= 0, state <= ACCUM.
- Latency: out_valid rises on the cycle after the final accepting edge. No bubble on the input side is required between bursts beyond the HOLD phase.
- Minimum throughput: one word per cycle in ACCUM.
- A word with in_last = 1 accepted as word LEN is a normal full burst; the two end conditions do not conflict.
- clr:
  - In ACCUM, clr sets mask <= 0 and count <= 0. Any word presented in the same cycle is not accepted; clr has priority and in_ready is still 1, but the data is dropped.
  - In HOLD, clr discards the result and returns to ACCUM with mask = 0 and count = 0.
  - clr has priority over out_ready.
- F_in containing X/Z is not defined. The bench only drives known values.
- out_ones is the combinational popcount of mask; out_all = &mask.
- Widths:
  - count saturates logically at LEN, since the state changes at LEN.
  - With the default LEN = 4, out_words is 3 bits.
- Asynchronous rst in HOLD drops out_valid immediately, without waiting for a clock edge.
- No other asynchronous paths exist.

Decomposition:
- Package or_accum_pkg holds:
  - typedef enum logic {ACCUM, HOLD} state_t
  - width helper localparams/functions for $clog2(n+1) and $clog2(LEN+1)
- One natural sub-module: popcount_n, a parametric combinational popcount producing out_ones. It is reusable by neighbouring gate blocks.

Test Plan:
- Reset: hold rst = 1 for 3 cycles.
  - Required: out_valid = 0, out_mask = 0000, in_ready = 0 throughout.
  - After release: in_ready = 1 on the next sample.
- Full burst, n = 4, LEN = 4: accept 1010, 0101, 0000, 0000 on consecutive cycles.
  - Required on the cycle after the 4th accept: out_valid = 1, out_mask = 1111, out_ones = 4, out_words = 4, out_all = 1, in_ready = 0.
- Early last: accept 1100, then 0000 with in_last = 1.
  - Required: out_mask = 1100, out_ones = 2, out_words = 2, out_all = 0.
- Backpressure: in HOLD with out_mask = 1100, keep out_ready = 0 for 5 cycles while in_valid = 1 and F_in = 0011.
  - Required: all outputs stable, no word accepted.
  - Then set out_ready = 1. Required on the next cycle: out_valid = 0, in_ready = 1.
  - The following burst starting with 0001 gives out_mask = 0001, proving the mask was cleared.
- clr mid-burst: accept 0001 and 0010, then pulse clr with in_valid = 1 and F_in = 1000.
  - Required: the 1000 is dropped.
  - The next full burst of 0100 x4 yields out_mask = 0100, out_words = 4.
- Async reset in HOLD: assert rst 3 ns after a clk edge.
  - Required: out_valid = 0 and out_mask = 0000 before the next clk edge.
